// File: rtl/apb_seq_pkg.sv
// rtl/apb_seq_pkg.sv - shared types and constants for the APB table sequencer
package apb_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH_C = 3'd1,
        ST_FETCH_D = 3'd2,
        ST_LOAD    = 3'd3,
        ST_SETUP   = 3'd4,
        ST_ACCESS  = 3'd5,
        ST_FIN     = 3'd6
    } state_e;

    // Command-word flag positions, as offsets above the address field (bit AW + offset)
    localparam int CMD_LAST_OFS  = 3;
    localparam int CMD_WRITE_OFS = 2;
    localparam int CMD_CHECK_OFS = 1;

    localparam int CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/apb_table_sequencer_if.sv
// rtl/apb_table_sequencer_if.sv - APB bus bundle with master/slave views
interface apb_table_sequencer_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic          PSEL;
    logic          PENABLE;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    modport master (
        output PADDR, PWRITE, PWDATA, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWRITE, PWDATA, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_seq_watchdog.sv
// rtl/apb_seq_watchdog.sv - ACCESS-phase cycle counter flagging the TIMEOUT-th wait cycle
module apb_seq_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q = ACCESS cycles already spent; expiry marks the cycle that is number TIMEOUT
    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

    // Cleared in SETUP so every transfer gets a fresh budget
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/apb_table_sequencer.sv
// rtl/apb_table_sequencer.sv - walks a {cmd,data} table and issues one APB transfer per entry
module apb_table_sequencer
    import apb_seq_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TBL_DEPTH = 256,
    parameter int TIMEOUT   = 16,
    parameter bit ABORT_ERR = 1'b0
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         tbl_rd,
    output logic [$clog2(TBL_DEPTH)-1:0] tbl_addr,
    input  logic [AW+3:0]                tbl_rdata,
    apb_table_sequencer_if.master        apb,
    output logic [CNT_W-1:0]             xfer_cnt,
    output logic [CNT_W-1:0]             err_cnt,
    output logic [CNT_W-1:0]             mism_cnt
);
    localparam int PW = $clog2(TBL_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(TBL_DEPTH - 2);

    localparam int B_LAST  = AW + CMD_LAST_OFS;
    localparam int B_WRITE = AW + CMD_WRITE_OFS;
    localparam int B_CHECK = AW + CMD_CHECK_OFS;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [AW+3:0]   cmd_q, cmd_d;
    logic [DW-1:0]   data_q, data_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic            pwrite_q, pwrite_d;
    logic [DW-1:0]   pwdata_q, pwdata_d;
    logic [CNT_W-1:0] xfer_q, xfer_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] mism_q, mism_d;
    logic            expired;
    logic            step_err;

    apb_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk_i     (PCLK),
        .rst_n_i   (PRESETn),
        .load_i    (state_q == ST_SETUP),
        .en_i      (state_q == ST_ACCESS),
        .expired_o (expired)
    );

    // Strobes decoded straight from state so an async reset clears them in the same instant
    always_comb begin
        tbl_rd      = 1'b0;
        tbl_addr    = '0;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_q)
            ST_FETCH_C: begin
                tbl_rd   = 1'b1;
                tbl_addr = ptr_q;
                busy     = 1'b1;
            end
            ST_FETCH_D: begin
                tbl_rd   = 1'b1;
                tbl_addr = ptr_q + PW'(1);
                busy     = 1'b1;
            end
            ST_LOAD: busy = 1'b1;
            ST_SETUP: begin
                apb.PSEL = 1'b1;
                busy     = 1'b1;
            end
            ST_ACCESS: begin
                apb.PSEL    = 1'b1;
                apb.PENABLE = 1'b1;
                busy        = 1'b1;
            end
            ST_FIN: done = 1'b1;
            default: ;
        endcase
    end

    assign apb.PADDR  = paddr_q;
    assign apb.PWRITE = pwrite_q;
    assign apb.PWDATA = pwdata_q;
    assign xfer_cnt   = xfer_q;
    assign err_cnt    = err_q;
    assign mism_cnt   = mism_q;

    // Next-state: fetch two words, load the bus registers, run SETUP/ACCESS, then advance or finish
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cmd_d    = cmd_q;
        data_d   = data_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        xfer_d   = xfer_q;
        err_d    = err_q;
        mism_d   = mism_q;
        step_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH_C;
                    ptr_d   = '0;
                    xfer_d  = '0;
                    err_d   = '0;
                    mism_d  = '0;
                end
            end
            ST_FETCH_C: state_d = ST_FETCH_D;
            ST_FETCH_D: begin
                cmd_d   = tbl_rdata;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                data_d   = tbl_rdata[DW-1:0];
                paddr_d  = cmd_q[AW-1:0];
                pwrite_d = cmd_q[B_WRITE];
                pwdata_d = cmd_q[B_WRITE] ? tbl_rdata[DW-1:0] : '0;
                state_d  = ST_SETUP;
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (apb.PREADY || expired) begin
                    if (apb.PREADY) begin
                        xfer_d = sat_inc(xfer_q);
                        if (apb.PSLVERR) begin
                            step_err = 1'b1;
                            err_d    = sat_inc(err_q);
                        end else if (!cmd_q[B_WRITE] && cmd_q[B_CHECK] &&
                                     (apb.PRDATA != data_q)) begin
                            mism_d = sat_inc(mism_q);
                        end
                    end else begin
                        step_err = 1'b1;
                        err_d    = sat_inc(err_q);
                    end
                    if (cmd_q[B_LAST] || (ptr_q == PTR_LAST) || (step_err && ABORT_ERR)) begin
                        state_d = ST_FIN;
                    end else begin
                        ptr_d   = ptr_q + PW'(2);
                        state_d = ST_FETCH_C;
                    end
                end
            end
            ST_FIN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, table pointer, latched entry, bus registers and counters
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            cmd_q    <= '0;
            data_q   <= '0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            xfer_q   <= '0;
            err_q    <= '0;
            mism_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cmd_q    <= cmd_d;
            data_q   <= data_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            xfer_q   <= xfer_d;
            err_q    <= err_d;
            mism_q   <= mism_d;
        end
    end
endmodule
